// File: rtl/set_sched_pkg.sv
// set_sched_pkg: shared mode encoding, scheduler states and the queued command record
package set_sched_pkg;
  localparam int TAG_MAX = 16;
  typedef enum logic [1:0] {MODE_A, MODE_AND, MODE_XOR, MODE_ILL} mode_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;
  typedef struct packed {
    logic [TAG_MAX-1:0] tag;
    logic [23:0]        central;
    logic [11:0]        radius;
    mode_t              mode;
  } cmd_t;
endpackage

// File: rtl/set_cmd_fifo.sv
// set_cmd_fifo: synchronous command FIFO with full/empty flags and fill count
module set_cmd_fifo
  import set_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  cmd_t                   din,
  output cmd_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  cmd_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/set_cmd_scheduler.sv
// set_cmd_scheduler: queues host commands and issues them one at a time to the SET engine
module set_cmd_scheduler
  import set_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic [23:0]      cmd_central,
  input  logic [11:0]      cmd_radius,
  input  logic [1:0]       cmd_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [7:0]       res_count,
  output logic             res_err,
  output logic             eng_en,
  output logic [23:0]      eng_central,
  output logic [11:0]      eng_radius,
  output logic [1:0]       eng_mode,
  input  logic             eng_busy,
  input  logic             eng_valid,
  input  logic [7:0]       eng_candidate
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  cmd_t din, head;
  state_t state;
  logic full, empty, pop, can_start, illegal, unused_ok;
  logic [$clog2(DEPTH):0] count;
  logic [TW-1:0] timer;
  logic [TAG_W-1:0] cur_tag;
  assign din = '{tag: TAG_MAX'(cmd_tag), central: cmd_central, radius: cmd_radius, mode: mode_t'(cmd_mode)};
  assign cmd_ready = !full;
  assign can_start = state == S_IDLE && !empty && (!res_valid || res_ready) && !eng_busy;
  assign illegal = head.mode == MODE_ILL;
  assign pop = state == S_ISSUE || (can_start && illegal);
  assign unused_ok = ^{count, head.tag};
  set_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // timer is held at zero in IDLE and starts counting in ISSUE, so it equals cycles since eng_en
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      timer <= '0;
      cur_tag <= '0;
      eng_en <= 1'b0;
      eng_central <= '0;
      eng_radius <= '0;
      eng_mode <= '0;
      res_valid <= 1'b0;
      res_tag <= '0;
      res_count <= '0;
      res_err <= 1'b0;
    end else begin
      eng_en <= 1'b0;
      timer <= (state == S_IDLE) ? '0 : (&timer ? timer : timer + TW'(1));
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        S_IDLE:
          if (can_start && illegal) begin
            res_valid <= 1'b1;
            res_tag <= TAG_W'(head.tag);
            res_count <= '0;
            res_err <= 1'b1;
          end else if (can_start) begin
            state <= S_ISSUE;
            eng_en <= 1'b1;
            eng_central <= head.central;
            eng_radius <= head.radius;
            eng_mode <= head.mode;
            cur_tag <= TAG_W'(head.tag);
          end
        S_ISSUE: state <= S_WAIT;
        S_WAIT:
          if (eng_valid || timer == TW'(TIMEOUT - 1)) begin
            res_valid <= 1'b1;
            res_tag <= cur_tag;
            res_count <= eng_valid ? eng_candidate : '0;
            res_err <= !eng_valid;
            state <= S_DRAIN;
          end
        S_DRAIN: if (!eng_busy) state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_set_cmd_scheduler.sv
// tb_set_cmd_scheduler: directed and randomized checks of the scheduler against a result scoreboard
module tb_set_cmd_scheduler;
  localparam int TIMEOUT = 128;
  localparam int STALL_LEN = 160;
  logic clk = 0, rst = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [3:0] cmd_tag = 0;
  logic [23:0] cmd_central = 0;
  logic [11:0] cmd_radius = 0;
  logic [1:0] cmd_mode = 0;
  logic res_valid, res_ready = 0, res_err;
  logic [3:0] res_tag;
  logic [7:0] res_count;
  logic eng_en;
  logic [23:0] eng_central;
  logic [11:0] eng_radius;
  logic [1:0] eng_mode;
  logic eng_busy = 0, eng_valid = 0;
  logic [7:0] eng_candidate = 0;
  int checks = 0, errors = 0, n_done = 0, n_en = 0;
  int eng_lat = 65, eng_tail = 2, e_cnt = 0, e_tail = 0;
  bit eng_stall = 0, eng_rand = 0, e_stall = 0, rand_rdy = 0;
  logic [23:0] e_c;
  logic [11:0] e_r;
  logic [1:0] e_m;
  typedef struct {logic [3:0] tag; logic [7:0] count; logic err;} res_t;
  res_t exp_q[$];

  set_cmd_scheduler #(.DEPTH(4), .TAG_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag),
    .cmd_central(cmd_central), .cmd_radius(cmd_radius), .cmd_mode(cmd_mode),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_count(res_count),
    .res_err(res_err), .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius),
    .eng_mode(eng_mode), .eng_busy(eng_busy), .eng_valid(eng_valid), .eng_candidate(eng_candidate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // Points of the 8x8 grid (1..8) inside circle A, both circles, or exactly one
  function automatic int ref_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int n = 0;
    int dx1, dy1, dx2, dy2;
    bit a, b;
    for (int x = 1; x <= 8; x++)
      for (int y = 1; y <= 8; y++) begin
        dx1 = x - int'(c[23:20]); dy1 = y - int'(c[19:16]);
        dx2 = x - int'(c[15:12]); dy2 = y - int'(c[11:8]);
        a = dx1 * dx1 + dy1 * dy1 <= int'(r[11:8]) * int'(r[11:8]);
        b = dx2 * dx2 + dy2 * dy2 <= int'(r[7:4]) * int'(r[7:4]);
        n += (m == 0) ? int'(a) : (m == 1) ? int'(a && b) : int'(a ^ b);
      end
    return n;
  endfunction

  // Behavioural engine: latches on en, busy for latency+tail cycles, valid once at the latency point
  always @(negedge clk) begin
    eng_valid = 0;
    if (!rst) begin
      eng_busy = 0;
      e_cnt = 0;
    end else if (eng_en) begin
      chk("en_while_busy", eng_busy, 0);
      n_en++;
      e_c = eng_central; e_r = eng_radius; e_m = eng_mode; e_stall = eng_stall;
      e_tail = eng_rand ? int'($urandom_range(0, 3)) : eng_tail;
      e_cnt = e_stall ? STALL_LEN : (eng_rand ? int'($urandom_range(1, 90)) : eng_lat) + e_tail;
      eng_busy = 1;
    end else if (eng_busy) begin
      e_cnt--;
      if (!e_stall && e_cnt == e_tail) begin
        eng_valid = 1;
        eng_candidate = 8'(ref_count(e_c, e_r, e_m));
      end
      if (e_cnt == 0) eng_busy = 0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("res_unexpected", 32'(exp_q.size()), 1);
      else begin
        res_t e;
        e = exp_q.pop_front();
        chk("res_tag", res_tag, e.tag);
        chk("res_count", res_count, e.count);
        chk("res_err", res_err, e.err);
      end
      n_done++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [3:0] tag, input logic [23:0] c, input logic [11:0] r,
                      input logic [1:0] m, input bit stall);
    int b = 0;
    bit err;
    while (!cmd_ready && b < 500) begin tick(); b++; end
    chk("push_ready", cmd_ready, 1);
    err = (m == 3) || stall;
    cmd_valid = 1; cmd_tag = tag; cmd_central = c; cmd_radius = r; cmd_mode = m;
    exp_q.push_back('{tag: tag, count: err ? 8'd0 : 8'(ref_count(c, r, m)), err: err});
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int b = 0;
    while (n_done < target && b < budget) begin tick(); b++; end
    chk("done_count", n_done, target);
  endtask

  task automatic check_reset_outputs();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_eng_en", eng_en, 0);
    chk("rst_eng_central", eng_central, 0);
    chk("rst_eng_radius", eng_radius, 0);
    chk("rst_eng_mode", eng_mode, 0);
  endtask

  initial begin
    int k, e0, d0;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1; res_ready = 1;
    tick();
    // single mode-0 command: issue latency, one-cycle en, result latency
    push(4'd5, 24'h440000, 12'h300, 2'd0, 0);
    chk("lat_t1_en", eng_en, 0);
    tick();
    chk("lat_t2_en", eng_en, 1);
    chk("eng_central", eng_central, 24'h440000);
    chk("eng_radius", eng_radius, 12'h300);
    chk("eng_mode", eng_mode, 0);
    tick();
    chk("en_pulse", eng_en, 0);
    k = 1;
    while (!res_valid && k < 300) begin tick(); k++; end
    chk("res_latency", k, 66);
    wait_done(1, 50);
    // engine strobe while idle must be ignored
    eng_valid = 1; eng_candidate = 8'hAA;
    tick(); tick();
    chk("stray_valid", res_valid, 0);
    // intersection and xor of identical circles
    push(4'd1, 24'h444400, 12'h330, 2'd1, 0);
    push(4'd2, 24'h444400, 12'h330, 2'd2, 0);
    wait_done(3, 400);
    // five back-to-back commands fill the FIFO
    eng_lat = 40;
    for (int i = 0; i < 5; i++)
      push(4'(8 + i), {4'(i + 1), 4'd3, 4'd5, 4'd4, 8'h00}, {4'(i % 4 + 1), 4'd2, 4'h0}, 2'(i % 3), 0);
    chk("full_after_5", cmd_ready, 0);
    wait_done(8, 600);
    chk("ready_after_drain", cmd_ready, 1);
    // illegal mode sandwiched between legal commands
    e0 = n_en;
    push(4'd3, 24'h440000, 12'h300, 2'd0, 0);
    push(4'd4, 24'h444400, 12'h330, 2'd3, 0);
    push(4'd6, 24'h444400, 12'h330, 2'd1, 0);
    wait_done(11, 400);
    chk("illegal_no_start", n_en - e0, 2);
    // engine never reports: timeout, then reissue only once busy falls
    eng_stall = 1;
    push(4'd9, 24'h440000, 12'h300, 2'd0, 1);
    push(4'd10, 24'h444400, 12'h330, 2'd2, 0);
    chk("to_en", eng_en, 1);
    eng_stall = 0;
    k = 0;
    while (!res_valid && k < 400) begin tick(); k++; end
    chk("timeout_lat", k, TIMEOUT);
    chk("timeout_err", res_err, 1);
    while (!eng_en && k < 600) begin tick(); k++; end
    chk("reissue_gap", k, STALL_LEN + 2);
    wait_done(13, 300);
    // host stalls the result channel
    eng_lat = 20; res_ready = 0;
    e0 = n_en; d0 = n_done;
    push(4'd11, 24'h440000, 12'h300, 2'd0, 0);
    push(4'd12, 24'h444400, 12'h330, 2'd1, 0);
    push(4'd13, 24'h444400, 12'h330, 2'd2, 0);
    repeat (200) tick();
    chk("held_one_issue", n_en - e0, 1);
    chk("held_no_done", n_done - d0, 0);
    chk("held_valid", res_valid, 1);
    chk("held_tag", res_tag, 11);
    res_ready = 1;
    wait_done(16, 300);
    // reset in the middle of WAIT
    push(4'd14, 24'h440000, 12'h300, 2'd0, 0);
    k = 0;
    while (!eng_en && k < 50) begin tick(); k++; end
    chk("pre_reset_en", eng_en, 1);
    repeat (10) tick();
    rst = 0;
    exp_q.delete();
    tick();
    check_reset_outputs();
    rst = 1;
    tick();
    push(4'd15, 24'h444400, 12'h330, 2'd1, 0);
    wait_done(17, 300);
    // randomized traffic with random host back-pressure and engine latency
    rand_rdy = 1; eng_rand = 1;
    for (int i = 0; i < 40; i++) begin
      push(4'($urandom), {16'($urandom), 8'h00}, {8'($urandom), 4'h0}, 2'($urandom_range(0, 3)), 0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_rdy = 0; res_ready = 1;
    wait_done(57, 8000);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/set_cmd_scheduler.md
# set_cmd_scheduler

Command front-end for the SET circle-counting engine. It buffers host commands (two circles plus an operation mode) in a small FIFO and issues them one at a time to the engine over its `en`/`busy`/`valid`/`candidate` handshake. Each engine count is returned to the host as a tagged result on a valid/ready channel. It sits directly upstream of the engine and owns every engine control pin.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries (power of two, ≥2)
- `TAG_W`, 4: host tag width
- `TIMEOUT`, 128: max cycles from `en` to engine `valid` before error

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  host command present
- `cmd_ready`  out  1  FIFO not full
- `cmd_tag`  in  TAG_W  host tag, echoed on the result
- `cmd_central`  in  24  {x1,y1,x2,y2,8'b0} nibbles
- `cmd_radius`  in  12  {r1,r2,4'b0}
- `cmd_mode`  in  2  0=|A|, 1=|A∩B|, 2=|A xor B|, 3=illegal
- `res_valid`  out  1  result held
- `res_ready`  in  1  host accepts result
- `res_tag`  out  TAG_W  tag of completed command
- `res_count`  out  8  engine candidate count
- `res_err`  out  1  illegal mode or timeout
- `eng_en`  out  1  one-cycle start pulse to engine
- `eng_central`  out  24  to engine
- `eng_radius`  out  12  to engine
- `eng_mode`  out  2  to engine
- `eng_busy`  in  1  engine busy
- `eng_valid`  in  1  engine result strobe (one cycle)
- `eng_candidate`  in  8  engine count, qualified by `eng_valid`

## Operation
- Command is written into the FIFO on `cmd_valid && cmd_ready`. `cmd_ready` = !full.
- FSM states and transitions:
  - IDLE: FIFO non-empty, `res_valid`=0 and `eng_busy`=0 → ISSUE. Head mode==3 → pop, load result {tag, count 0, err 1}, stay IDLE; engine is not started.
  - ISSUE: drive `eng_en`=1 for exactly one cycle with head fields on `eng_*`, pop head, clear timer → WAIT.
  - WAIT: timer counts up each cycle.
    - On `eng_valid`: capture `eng_candidate` and tag, set `res_err`=0, assert `res_valid` → DRAIN.
    - On timer == TIMEOUT−1 with no `eng_valid`: result {tag, 0, err 1} → DRAIN.
  - DRAIN: wait for `eng_busy`=0 → IDLE.
- `eng_en` must never assert while `eng_busy`=1; the engine reloads on any `en` and would lose work.
- `eng_central/radius/mode` are registered and hold their last issued value outside ISSUE.
- Result register is single-entry. While `res_valid`=1 and `res_ready`=0, no new command is issued. The FIFO keeps accepting commands until full.
- Commands complete strictly in FIFO order.

## Timing
- Reset values: `cmd_ready`=1, `res_valid`=0, `res_tag`=0, `res_count`=0, `res_err`=0, `eng_en`=0, `eng_central`=0, `eng_radius`=0, `eng_mode`=0, FSM=IDLE, FIFO empty, timer 0.
- Reset mid-command: all state is cleared, and the in-flight command and result are lost.
- Latency, empty FIFO: command accepted at cycle t → `eng_en` at t+2 (t+1 IDLE decision, t+2 ISSUE).
  - Engine reports `valid` 65 cycles after `en` → `res_valid` one cycle after `eng_valid`.
  - No logic depends on the exact 65.
- Result handshake: `res_valid` drops the cycle after `res_valid && res_ready`. The next issue can occur in that same cycle if the FSM is in IDLE.
- Simultaneous push and pop on the FIFO is legal at any fill level except a push while full.
- `eng_valid` arriving outside WAIT is ignored.
- Timer width = clog2(TIMEOUT)+1. Timer saturates and is not used outside WAIT.

## Structure
- Package `set_sched_pkg`:
  - mode constants `MODE_A`, `MODE_AND`, `MODE_XOR`, `MODE_ILL`
  - FSM state enum
  - packed command struct {tag, central, radius, mode}
- Sub-module `set_cmd_fifo`: synchronous FIFO, DEPTH×struct width, with full/empty flags and count. The FSM stays in the top level.

## Test plan
- Mode 0, central 0x440000, radius 0x300, tag 5, `res_ready`=1 → one `eng_en` pulse, then `res_count`=29, `res_tag`=5, `res_err`=0.
- Mode 1 and mode 2, both circles at (4,4) with r=3 (central 0x444400, radius 0x330) → counts 29 and 0, in order.
- Five back-to-back commands with DEPTH=4 and the engine busy → `cmd_ready` low after the FIFO fills; all five results return in order, and `eng_en` never asserts while `eng_busy`=1.
- Mode 3 command between two legal ones → the engine is not started for it; result is count 0, err 1, with its tag, in sequence.
- Engine model never asserts `eng_valid` → `res_err`=1 exactly TIMEOUT cycles after `eng_en`; the next command issues after `eng_busy` falls.
- Hold `res_ready`=0 for 200 cycles, then release → only one command completes while held; the reset pulse mid-WAIT returns all outputs to reset values.
